// File: rtl/poly1305_final_pipe.sv
// Poly1305 final reduction and tag pipeline.
// Takes the 160-bit accumulator h, applies the mod-(2^130-5) correction
// (h + 5*q, q = (h + 5) >> 130), optionally adds the key half s and emits the
// 128-bit tag. Stage 1 holds the corrected h and selected s; the optional
// stage 2 holds the finished tag. Valid/ready handshake on both sides, with
// bubble collapsing and a synchronous flush.
module poly1305_final_pipe #(
    parameter int CH_W    = 2,
    parameter int OUT_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic            in_add_s,
    input  logic [31:0]     h0,
    input  logic [31:0]     h1,
    input  logic [31:0]     h2,
    input  logic [31:0]     h3,
    input  logic [31:0]     h4,
    input  logic [31:0]     s0,
    input  logic [31:0]     s1,
    input  logic [31:0]     s2,
    input  logic [31:0]     s3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic [31:0]     hres0,
    output logic [31:0]     hres1,
    output logic [31:0]     hres2,
    output logic [31:0]     hres3,
    output logic            out_range_err,
    output logic [1:0]      in_flight
);

    // q = (h + 5) >> 130 without a full 161-bit adder: the low 130 bits only
    // contribute a carry when they are >= 2^130 - 5.
    function automatic logic [30:0] calc_q(input logic [159:0] h);
        logic carry;
        carry = (&h[129:3]) & (h[2:0] >= 3'd3);
        return {1'b0, h[159:130]} + {30'd0, carry};
    endfunction

    // The tag is taken mod 2^128, so only the low 128 bits of h + 5*q matter.
    function automatic logic [127:0] correct_h(input logic [159:0] h, input logic [30:0] q);
        logic [32:0] q5;
        q5 = {q, 2'b00} + {2'b00, q};
        return h[127:0] + {95'd0, q5};
    endfunction

    logic [159:0]    h_in_s;
    logic [127:0]    s_in_s;
    logic [30:0]     q_s;
    logic [127:0]    hc_s;
    logic [127:0]    s_sel_s;
    logic            err_s;
    logic            load_s;
    logic            s1_acc_s;
    logic            s2_acc_s;

    logic            s1_valid_q;
    logic            s1_valid_d;
    logic [CH_W-1:0] s1_ch_q;
    logic [CH_W-1:0] s1_ch_d;
    logic [127:0]    s1_hc_q;
    logic [127:0]    s1_hc_d;
    logic [127:0]    s1_s_q;
    logic [127:0]    s1_s_d;
    logic            s1_err_q;
    logic            s1_err_d;
    logic [127:0]    s1_tag_s;

    logic            out_valid_s;
    logic [CH_W-1:0] out_ch_s;
    logic [127:0]    out_tag_s;
    logic            out_err_s;
    logic            s2_cnt_s;

    assign h_in_s  = {h4, h3, h2, h1, h0};
    assign s_in_s  = {s3, s2, s1, s0};
    assign q_s     = calc_q(h_in_s);
    assign hc_s    = correct_h(h_in_s, q_s);
    assign err_s   = |q_s[30:1];
    assign s_sel_s = in_add_s ? s_in_s : 128'd0;

    assign s1_acc_s = ~s1_valid_q | s2_acc_s;
    assign in_ready = s1_acc_s & ~flush & ~reset;
    assign load_s   = in_valid & in_ready;
    assign s1_tag_s = s1_hc_q + s1_s_q;

    // Stage-1 next state: flush empties it, otherwise it refills when it can move.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_hc_d    = s1_hc_q;
        s1_s_d     = s1_s_q;
        s1_err_d   = s1_err_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_acc_s) begin
            s1_valid_d = load_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (load_s) begin
            s1_ch_d  = in_ch;
            s1_hc_d  = hc_s;
            s1_s_d   = s_sel_s;
            s1_err_d = err_s;
        end else begin
            s1_ch_d  = s1_ch_q;
            s1_hc_d  = s1_hc_q;
            s1_s_d   = s1_s_q;
            s1_err_d = s1_err_q;
        end
    end

    // Stage-1 valid flag; the only stage-1 state that needs reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
    end

    // Stage-1 payload; validity is carried solely by s1_valid_q.
    always_ff @(posedge clk) begin
        s1_ch_q  <= s1_ch_d;
        s1_hc_q  <= s1_hc_d;
        s1_s_q   <= s1_s_d;
        s1_err_q <= s1_err_d;
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic            s2_valid_q;
        logic            s2_valid_d;
        logic [CH_W-1:0] s2_ch_q;
        logic [CH_W-1:0] s2_ch_d;
        logic [127:0]    s2_tag_q;
        logic [127:0]    s2_tag_d;
        logic            s2_err_q;
        logic            s2_err_d;

        assign s2_acc_s = ~s2_valid_q | out_ready;

        // Stage-2 next state: takes stage 1 whenever the output side can move.
        always_comb begin
            s2_valid_d = s2_valid_q;
            s2_ch_d    = s2_ch_q;
            s2_tag_d   = s2_tag_q;
            s2_err_d   = s2_err_q;
            if (flush) begin
                s2_valid_d = 1'b0;
            end else if (s2_acc_s) begin
                s2_valid_d = s1_valid_q;
            end else begin
                s2_valid_d = s2_valid_q;
            end
            if (s2_acc_s && s1_valid_q) begin
                s2_ch_d  = s1_ch_q;
                s2_tag_d = s1_tag_s;
                s2_err_d = s1_err_q;
            end else begin
                s2_ch_d  = s2_ch_q;
                s2_tag_d = s2_tag_q;
                s2_err_d = s2_err_q;
            end
        end

        // Stage-2 valid flag.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s2_valid_d;
            end
        end

        // Stage-2 payload; held unchanged while stalled.
        always_ff @(posedge clk) begin
            s2_ch_q  <= s2_ch_d;
            s2_tag_q <= s2_tag_d;
            s2_err_q <= s2_err_d;
        end

        assign out_valid_s = s2_valid_q;
        assign out_ch_s    = s2_ch_q;
        assign out_tag_s   = s2_tag_q;
        assign out_err_s   = s2_err_q;
        assign s2_cnt_s    = s2_valid_q;
    end else begin : g_out_comb
        assign s2_acc_s    = out_ready;
        assign out_valid_s = s1_valid_q;
        assign out_ch_s    = s1_ch_q;
        assign out_tag_s   = s1_tag_s;
        assign out_err_s   = s1_err_q;
        assign s2_cnt_s    = 1'b0;
    end

    // Outputs are qualified by valid so that reset forces them to zero at once
    // even though the payload registers themselves are not reset.
    assign out_valid     = out_valid_s;
    assign out_ch        = out_valid_s ? out_ch_s : {CH_W{1'b0}};
    assign out_range_err = out_valid_s & out_err_s;
    assign hres0         = out_valid_s ? out_tag_s[31:0]   : 32'd0;
    assign hres1         = out_valid_s ? out_tag_s[63:32]  : 32'd0;
    assign hres2         = out_valid_s ? out_tag_s[95:64]  : 32'd0;
    assign hres3         = out_valid_s ? out_tag_s[127:96] : 32'd0;
    assign in_flight     = {1'b0, s1_valid_q} + {1'b0, s2_cnt_s};

endmodule

// File: tb/tb_poly1305_final_pipe.sv
// Directed self-checking bench for poly1305_final_pipe (OUT_REG=1).
module tb_poly1305_final_pipe;
    localparam int CH_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic            in_add_s;
    logic [31:0]     h0, h1, h2, h3, h4;
    logic [31:0]     s0, s1, s2, s3;
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [31:0]     hres0, hres1, hres2, hres3;
    logic            out_range_err;
    logic [1:0]      in_flight;
    logic [127:0]    tag_w;

    int n_checks = 0;
    int n_errors = 0;

    assign tag_w = {hres3, hres2, hres1, hres0};

    always #5 clk = ~clk;

    poly1305_final_pipe #(.CH_W(CH_W), .OUT_REG(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_add_s(in_add_s),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3), .h4(h4),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .hres0(hres0), .hres1(hres1), .hres2(hres2), .hres3(hres3),
        .out_range_err(out_range_err), .in_flight(in_flight)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input logic [CH_W-1:0] ch, input logic add, input logic [159:0] h,
                           input logic [127:0] s);
        in_ch    = ch;
        in_add_s = add;
        {h4, h3, h2, h1, h0} = h;
        {s3, s2, s1, s0}     = s;
    endtask

    task automatic run_single(input string name, input logic [CH_W-1:0] ch, input logic add,
                              input logic [159:0] h, input logic [127:0] s,
                              input logic [127:0] exp_tag, input logic exp_err);
        set_job(ch, add, h, s);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val({name, "_in_ready"}, 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        check_val({name, "_lat1_valid"}, 128'(out_valid), 128'd0);
        step();
        check_val({name, "_valid"}, 128'(out_valid), 128'd1);
        check_val({name, "_tag"}, tag_w, exp_tag);
        check_val({name, "_err"}, 128'(out_range_err), 128'(exp_err));
        check_val({name, "_ch"}, 128'(out_ch), 128'(ch));
        step();
        check_val({name, "_drained"}, 128'(in_flight), 128'd0);
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        set_job(2'd0, 1'b1, 160'h11, 128'h0);
        in_valid = 1'b1;
        step();
        set_job(2'd1, 1'b1, 160'h22, 128'h0);
        step();
        in_valid = 1'b0;
        check_val("fill_in_flight", 128'(in_flight), 128'd2);
    endtask

    localparam logic [159:0] P_H = 160'h3_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFB;

    initial begin
        int sent;
        int recv;
        int seen;
        logic acc;
        logic cons;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_job(2'd0, 1'b0, 160'h0, 128'h0);
        #3;
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_in_flight", 128'(in_flight), 128'd0);
        check_val("rst_in_ready", 128'(in_ready), 128'd0);
        check_val("rst_tag", tag_w, 128'd0);
        check_val("rst_err_ch", 128'({out_range_err, out_ch}), 128'd0);
        #9;
        reset = 1'b0;
        step();
        check_val("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Arithmetic vectors: expectations worked by hand from q=(h+5)>>130.
        run_single("h_eq_p", 2'd1, 1'b1, P_H, 128'd0, 128'd0, 1'b0);
        run_single("p_m1_adds", 2'd2, 1'b1, P_H - 160'd1, 128'd1,
                   128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFB, 1'b0);
        run_single("p_m1_nos", 2'd3, 1'b0, P_H - 160'd1, 128'd1,
                   128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFA, 1'b0);
        run_single("h_2p131", 2'd0, 1'b1, 160'h8_00000000_00000000_00000000_00000000, 128'd0,
                   128'h0000000A, 1'b1);
        run_single("small", 2'd1, 1'b1, 160'h1, 128'h2, 128'h3, 1'b0);
        run_single("q1_top", 2'd2, 1'b1, 160'h7_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFA, 128'd0,
                   128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0);
        run_single("q2_bottom", 2'd3, 1'b1, 160'h7_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFB, 128'd0,
                   128'h5, 1'b1);
        run_single("h_2p159", 2'd0, 1'b0, 160'h80000000_00000000_00000000_00000000_00000000,
                   128'd7, 128'hA0000000, 1'b1);

        // Back-pressure: four jobs, output stalled for the first three cycles.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = (cyc >= 3);
            if (sent < 4) begin
                set_job(CH_W'(sent), 1'b1, 160'(sent + 1), 128'(sent * 256));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                check_val("bp_in_ready_drop", 128'(in_ready), 128'd0);
                check_val("bp_in_flight", 128'(in_flight), 128'd2);
            end
            if (out_valid) begin
                check_val("bp_order_ch", 128'(out_ch), 128'(recv));
                check_val("bp_tag", tag_w, 128'(recv + 1 + recv * 256));
            end
            acc  = in_valid & in_ready;
            cons = out_valid & out_ready;
            step();
            if (acc) sent++;
            if (cons) recv++;
        end
        in_valid = 1'b0;
        check_val("bp_sent", 128'(sent), 128'd4);
        check_val("bp_recv", 128'(recv), 128'd4);

        // Asynchronous reset with two jobs in flight.
        fill_two();
        #3;
        reset = 1'b1;
        #1;
        check_val("arst_out_valid", 128'(out_valid), 128'd0);
        check_val("arst_in_flight", 128'(in_flight), 128'd0);
        check_val("arst_in_ready", 128'(in_ready), 128'd0);
        check_val("arst_tag", tag_w, 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (out_valid) seen++;
        end
        check_val("arst_no_stale", 128'(seen), 128'd0);

        // Flush with two jobs in flight and a job on offer.
        fill_two();
        set_job(2'd2, 1'b1, 160'h55, 128'h100);
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check_val("flush_in_ready", 128'(in_ready), 128'd0);
        step();
        flush = 1'b0;
        #1;
        check_val("flush_in_flight", 128'(in_flight), 128'd0);
        check_val("flush_out_valid", 128'(out_valid), 128'd0);
        check_val("flush_ready_after", 128'(in_ready), 128'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_val("flush_accept", 128'(in_flight), 128'd1);
        step();
        check_val("flush_job_valid", 128'(out_valid), 128'd1);
        check_val("flush_job_ch", 128'(out_ch), 128'd2);
        check_val("flush_job_tag", tag_w, 128'h155);
        step();
        check_val("flush_drained", 128'(in_flight), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
